// File: rtl/btn_event_queue_pkg.sv
// Shared types for the button event queue: event codes, per-button FSM states
// and the packed event word that travels through the FIFO.
package btn_event_queue_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_fsm_e;

    localparam int NUM_CODES = 4;
    localparam int HOLD_W    = 16;
    localparam int BTN_IDX_W = 3;
    localparam int EVT_W     = BTN_IDX_W + 2;

    // FIFO word layout: {button index, event code}
    function automatic logic [EVT_W-1:0] pack_evt(input logic [BTN_IDX_W-1:0] btn,
                                                   input logic [1:0]           code);
        return {btn, code};
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word fall-through FIFO with wrap-around pointers (extra MSB separates
// full from empty). A push while full is accepted only alongside a pop.
module evt_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: only state that shapes the outputs is reset; non-blocking (<=) everywhere in clocked logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately left unreset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/btn_event_queue.sv
// Button event generator: per-button press/hold FSMs raise pending event bits,
// a fixed-priority arbiter moves one per cycle into the event FIFO.
module btn_event_queue
    import btn_event_queue_pkg::*;
#(
    parameter int NBTN         = 5,
    parameter int TICK_DIV     = 25000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int DEPTH        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_i,
    output logic            evt_valid,
    output logic [1:0]      evt_code,
    output logic [2:0]      evt_btn,
    input  logic            evt_ready,
    output logic [NBTN-1:0] btn_state,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] LONG_LIM   = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] REPEAT_LIM = HOLD_W'(REPEAT_TICKS);

    logic [PW-1:0]                      r_presc;
    logic                               w_tick;
    logic [NBTN-1:0]                    r_btn_state;
    btn_fsm_e                           r_st      [NBTN];
    btn_fsm_e                           w_st_nxt  [NBTN];
    logic [NBTN-1:0][HOLD_W-1:0]        r_hold;
    logic [NBTN-1:0][HOLD_W-1:0]        w_hold_nxt;
    logic [NBTN-1:0][NUM_CODES-1:0]     w_raise;
    logic [NBTN-1:0][NUM_CODES-1:0]     r_pend;
    logic [NBTN-1:0][NUM_CODES-1:0]     w_pend_nxt;
    logic [NBTN-1:0][NUM_CODES-1:0]     w_grant_oh;
    logic                               w_grant_vld;
    logic [EVT_W-1:0]                   w_grant_evt;
    logic                               w_lost;
    logic                               r_ovf;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_full;
    logic [EVT_W-1:0]                   w_head;

    assign w_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_btn_state <= '0;
        end else begin
            r_presc     <= w_tick ? '0 : r_presc + 1'b1;
            r_btn_state <= btn_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBTN; b++) r_st[b] <= ST_IDLE;
            r_hold <= '0;
        end else begin
            for (int b = 0; b < NBTN; b++) r_st[b] <= w_st_nxt[b];
            r_hold <= w_hold_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    // A release wins over a tick landing in the same cycle.
    always_comb begin
        w_raise    = '0;
        w_hold_nxt = r_hold;
        for (int b = 0; b < NBTN; b++) begin
            w_st_nxt[b] = r_st[b];
            case (r_st[b])
                ST_IDLE: begin
                    if (btn_i[b] && !r_btn_state[b]) begin
                        w_st_nxt[b]          = ST_PRESSED;
                        w_hold_nxt[b]        = '0;
                        w_raise[b][EVT_PRESS] = 1'b1;
                    end
                end
                ST_PRESSED, ST_HELD: begin
                    if (!btn_i[b]) begin
                        w_st_nxt[b]             = ST_IDLE;
                        w_hold_nxt[b]           = '0;
                        w_raise[b][EVT_RELEASE] = 1'b1;
                    end else if (w_tick) begin
                        w_hold_nxt[b] = r_hold[b] + 1'b1;
                        if (r_st[b] == ST_PRESSED && w_hold_nxt[b] == LONG_LIM) begin
                            w_st_nxt[b]          = ST_HELD;
                            w_hold_nxt[b]        = '0;
                            w_raise[b][EVT_LONG] = 1'b1;
                        end else if (r_st[b] == ST_HELD && w_hold_nxt[b] == REPEAT_LIM) begin
                            w_hold_nxt[b]          = '0;
                            w_raise[b][EVT_REPEAT] = 1'b1;
                        end
                    end
                end
                default: begin
                    w_st_nxt[b]   = ST_IDLE;
                    w_hold_nxt[b] = '0;
                end
            endcase
        end
    end

    // Fixed priority: lowest button first, then lowest code within a button.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_evt = '0;
        w_grant_oh  = '0;
        for (int b = 0; b < NBTN; b++) begin
            for (int c = 0; c < NUM_CODES; c++) begin
                if (r_pend[b][c] && !w_grant_vld) begin
                    w_grant_vld      = 1'b1;
                    w_grant_evt      = pack_evt(BTN_IDX_W'(b), 2'(c));
                    w_grant_oh[b][c] = 1'b1;
                end
            end
        end
    end

    assign w_pop  = evt_valid && evt_ready;
    assign w_push = w_grant_vld && (!w_full || w_pop);

    // A bit granted this cycle is free again, so re-raising it is not a loss.
    always_comb begin
        w_lost     = 1'b0;
        w_pend_nxt = w_push ? (r_pend & ~w_grant_oh) : r_pend;
        for (int b = 0; b < NBTN; b++) begin
            for (int c = 0; c < NUM_CODES; c++) begin
                if (w_raise[b][c]) begin
                    if (w_pend_nxt[b][c]) w_lost = 1'b1;
                    w_pend_nxt[b][c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_lost)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_grant_evt),
        .i_pop   (w_pop),
        .o_valid (evt_valid),
        .o_full  (w_full),
        .o_data  (w_head)
    );

    assign evt_code  = w_head[1:0];
    assign evt_btn   = w_head[EVT_W-1:2];
    assign btn_state = r_btn_state;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench: a press-duration reference model feeds an expected-event
// queue; a negedge monitor compares every popped event and the status outputs.
module tb_btn_event_queue;

    localparam int NBTN    = 5;
    localparam int TD      = 4;
    localparam int LT      = 3;
    localparam int RT      = 2;
    localparam int DEPTH   = 4;
    localparam int C_PRESS = 0;
    localparam int C_REL   = 1;
    localparam int C_LONG  = 2;
    localparam int C_REP   = 3;

    logic            clk;
    logic            rst;
    logic [NBTN-1:0] btn_i;
    logic            evt_valid;
    logic [1:0]      evt_code;
    logic [2:0]      evt_btn;
    logic            evt_ready;
    logic [NBTN-1:0] btn_state;
    logic            ovf;
    logic            ovf_clr;

    btn_event_queue #(
        .NBTN         (NBTN),
        .TICK_DIV     (TD),
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_i),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_btn   (evt_btn),
        .evt_ready (evt_ready),
        .btn_state (btn_state),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int btn; int code; } exp_t;
    exp_t exp_q[$];

    int              m_edge;
    bit              m_active [NBTN];
    int              m_ticks  [NBTN];
    bit              m_pend   [NBTN][4];
    logic [NBTN-1:0] m_bs;
    int              m_cnt;
    bit              m_ovf;
    int              gb, gc, ev;
    bit              tick, pop, lost;

    always @(posedge clk) begin
        if (rst) begin
            m_edge = 0;
            m_bs   = '0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            for (int b = 0; b < NBTN; b++) begin
                m_active[b] = 1'b0;
                m_ticks[b]  = 0;
                for (int c = 0; c < 4; c++) m_pend[b][c] = 1'b0;
            end
            exp_q.delete();
        end else begin
            tick = ((m_edge % TD) == TD - 1);
            pop  = evt_ready && (m_cnt > 0);
            gb   = -1;
            gc   = -1;
            if (m_cnt < DEPTH || pop) begin
                for (int b = 0; b < NBTN && gb < 0; b++)
                    for (int c = 0; c < 4 && gb < 0; c++)
                        if (m_pend[b][c]) begin gb = b; gc = c; end
            end
            if (gb >= 0) begin
                m_pend[gb][gc] = 1'b0;
                exp_q.push_back('{btn: gb, code: gc});
                m_cnt++;
            end
            if (pop) m_cnt--;
            lost = 1'b0;
            for (int b = 0; b < NBTN; b++) begin
                ev = -1;
                if (!m_active[b] && btn_i[b]) begin
                    ev = C_PRESS;
                    m_active[b] = 1'b1;
                    m_ticks[b]  = 0;
                end else if (m_active[b] && !btn_i[b]) begin
                    ev = C_REL;
                    m_active[b] = 1'b0;
                end else if (m_active[b] && tick) begin
                    m_ticks[b]++;
                    if (m_ticks[b] == LT) ev = C_LONG;
                    else if (m_ticks[b] > LT && ((m_ticks[b] - LT) % RT) == 0) ev = C_REP;
                end
                if (ev >= 0) begin
                    if (m_pend[b][ev]) lost = 1'b1;
                    m_pend[b][ev] = 1'b1;
                end
                m_bs[b] = btn_i[b];
            end
            if (lost)         m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_edge++;
        end
    end

    // ---------------- monitor ----------------
    exp_t head;
    always @(negedge clk) begin
        if (!rst) begin
            check("evt_valid", 32'(evt_valid), 32'(m_cnt > 0));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("btn_state", 32'(btn_state), 32'(m_bs));
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(evt_valid), 32'(0));
                end else begin
                    head = exp_q.pop_front();
                    check("pop_code", 32'(evt_code), 32'(head.code));
                    check("pop_btn", 32'(evt_btn), 32'(head.btn));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_i     = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        step(3);
        check("rst_valid", 32'(evt_valid), 32'(0));
        check("rst_code", 32'(evt_code), 32'(0));
        check("rst_btn", 32'(evt_btn), 32'(0));
        check("rst_btn_state", 32'(btn_state), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        rst = 1'b0;
        step(10);

        // single press on button 2: valid exactly one edge after the sampling edge
        btn_i[2] = 1'b1;
        @(posedge clk); #1;
        check("lat_early_valid", 32'(evt_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_valid", 32'(evt_valid), 32'(1));
        check("lat_code", 32'(evt_code), 32'(C_PRESS));
        check("lat_btn", 32'(evt_btn), 32'(2));
        #1;
        btn_i[2] = 1'b0;
        step(8);

        // long hold on button 0: PRESS, LONG, REPEATs, RELEASE
        btn_i[0] = 1'b1;
        step(40);
        btn_i[0] = 1'b0;
        step(10);

        // simultaneous presses on buttons 4 and 1
        btn_i[4] = 1'b1;
        btn_i[1] = 1'b1;
        step(3);
        btn_i[4] = 1'b0;
        btn_i[1] = 1'b0;
        step(10);

        // stalled consumer: FIFO fills, pending holds, PRESS re-raise overflows
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_i[0] = 1'b1;
            step(2);
            btn_i[0] = 1'b0;
            step(2);
        end
        check("stall_ovf", 32'(ovf), 32'(1));
        check("stall_valid", 32'(evt_valid), 32'(1));
        check("stall_head_code", 32'(evt_code), 32'(C_PRESS));
        evt_ready = 1'b1;
        step(20);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(1);
        check("ovf_cleared", 32'(ovf), 32'(0));

        // reset while button 3 is held with events queued
        evt_ready = 1'b0;
        btn_i[3]  = 1'b1;
        step(16);
        check("pre_rst_valid", 32'(evt_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'(0));
        check("mid_rst_ovf", 32'(ovf), 32'(0));
        step(2);
        rst       = 1'b0;
        evt_ready = 1'b1;
        step(6);
        btn_i[3] = 1'b0;
        step(6);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < NBTN; b++)
                if ($urandom_range(0, 11) == 0) btn_i[b] = ~btn_i[b];
            evt_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 49) == 0);
            step(1);
        end

        // drain
        btn_i     = '0;
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        step(60);
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
